// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - ID-to-EX multiply/divide request and HI/LO result bundle
interface ex_muldiv_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              busy;
  logic              stallreq;
  logic              ready;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, src_a, src_b,
    input  busy, stallreq, ready, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b,
    output busy, stallreq, ready, hi, lo
  );
endinterface

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative 32-step mult/multu/div/divu unit with pipeline stall request
module ex_muldiv #(
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic                op_div;
  logic                sign_q;
  logic                sign_r;
  logic [DATA_W-1:0]   opnd;
  logic [2*DATA_W-1:0] acc;
  logic                busy_q;
  logic                ready_q;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;

  logic                accept;
  logic                in_signed;
  logic                div_zero;
  logic [DATA_W-1:0]   mag_a;
  logic [DATA_W-1:0]   mag_b;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W+1:0]   div_diff;
  logic [2*DATA_W-1:0] div_next;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;

  always_comb begin
    accept    = bus.start && (state == IDLE || state == DONE);
    in_signed = ~bus.op[0];
    div_zero  = bus.op[1] && (bus.src_b == '0);
    mag_a     = (in_signed && bus.src_a[DATA_W-1]) ? -bus.src_a : bus.src_a;
    mag_b     = (in_signed && bus.src_b[DATA_W-1]) ? -bus.src_b : bus.src_b;
  end

  // Multiply: multiplier sits in acc's low half and is consumed LSB first.
  always_comb begin
    mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[DATA_W-1:1]};
  end

  // Divide: acc = {remainder, dividend/quotient}; the extra sign bit of the
  // trial difference flags that the restoring step must keep the old remainder.
  always_comb begin
    div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    if (div_diff[DATA_W+1])
      div_next = {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
    else
      div_next = {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
  end

  always_comb begin
    prod_fix = sign_q ? -acc : acc;
    quo_fix  = sign_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    rem_fix  = sign_r ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept)
          state_next = div_zero ? DONE : CALC;
        else
          state_next = IDLE;
      end
      CALC: begin
        if (cnt == CNT_W'(DATA_W - 1))
          state_next = FIX;
      end
      FIX:     state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      op_div  <= 1'b0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      opnd    <= '0;
      acc     <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op_div <= bus.op[1];
            sign_q <= in_signed & (bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1]);
            sign_r <= in_signed & bus.src_a[DATA_W-1];
            opnd   <= bus.op[1] ? mag_b : mag_a;
            acc    <= {{DATA_W{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
            cnt    <= '0;
            if (div_zero) begin
              hi_q    <= bus.src_a;
              lo_q    <= '1;
              ready_q <= 1'b1;
            end else begin
              busy_q <= 1'b1;
            end
          end
        end
        CALC: begin
          acc <= op_div ? div_next : mul_next;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (op_div) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*DATA_W-1:DATA_W];
            lo_q <= prod_fix[DATA_W-1:0];
          end
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.ready    = ready_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.stallreq = (bus.start && (state == IDLE || state == DONE)) || busy_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - directed bench for ex_muldiv with transaction-level HI/LO model
module tb_ex_muldiv;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ex_muldiv_if bus_if ();

  ex_muldiv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: an accepted op produces its arithmetic result 34 cycles later
  // (busy for the 33 cycles between), divide by zero answers on the next cycle.
  int          m_cnt = 0;
  logic        m_ready = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [31:0] p_hi = '0, p_lo = '0;
  logic        m_valid = 1'b0;

  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    longint          q, r;
    case (o)
      2'b00:   return sa * sb;
      2'b01:   return ua * ub;
      2'b10: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: return {a % b, a / b};
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_cnt   <= 0;
      m_ready <= 1'b0;
      m_hi    <= '0;
      m_lo    <= '0;
      m_valid <= 1'b1;
    end else begin
      m_ready <= 1'b0;
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_hi    <= p_hi;
          m_lo    <= p_lo;
          m_ready <= 1'b1;
        end
      end else if (bus_if.start) begin
        if (bus_if.op[1] && bus_if.src_b == 32'h0) begin
          m_hi    <= bus_if.src_a;
          m_lo    <= 32'hFFFF_FFFF;
          m_ready <= 1'b1;
        end else begin
          {p_hi, p_lo} <= ref_result(bus_if.op, bus_if.src_a, bus_if.src_b);
          m_cnt        <= 33;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_busy", 32'(bus_if.busy), 32'(m_cnt > 0));
      chk("model_ready", 32'(bus_if.ready), 32'(m_ready));
      chk("model_stallreq", 32'(bus_if.stallreq), 32'((bus_if.start && m_cnt == 0) || m_cnt > 0));
      chk("model_hi", bus_if.hi, m_hi);
      chk("model_lo", bus_if.lo, m_lo);
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #2;
    bus_if.start = 1'b1;
    bus_if.op    = o;
    bus_if.src_a = a;
    bus_if.src_b = b;
  endtask

  // Walks cycles c0..exp_c of an op started in cycle 0, checking hand-computed
  // stall/busy/ready timing and the final HI/LO literals.
  task automatic wait_result(input string name, input int c0, input int exp_c,
                             input logic [31:0] eh, input logic [31:0] el,
                             input logic hold_en, input logic [31:0] hh, input logic [31:0] hl,
                             input int inj_c, input logic chain,
                             input logic [1:0] nop, input logic [31:0] na, input logic [31:0] nb);
    logic ok_stall = 1'b1, ok_ready = 1'b1, ok_busy = 1'b1, ok_hold = 1'b1;
    for (int c = c0; c <= exp_c; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #2;
        if (c == 1) bus_if.start = 1'b0;
        if (c == inj_c) begin
          bus_if.start = 1'b1;
          bus_if.op    = 2'b00;
          bus_if.src_a = 32'd2;
          bus_if.src_b = 32'd3;
        end
        if (c == inj_c + 1) bus_if.start = 1'b0;
        if (c == exp_c && chain) begin
          bus_if.start = 1'b1;
          bus_if.op    = nop;
          bus_if.src_a = na;
          bus_if.src_b = nb;
        end
      end
      @(negedge clk);
      if (bus_if.stallreq !== ((c < exp_c) || (c == exp_c && chain))) ok_stall = 1'b0;
      if (bus_if.ready !== (c == exp_c)) ok_ready = 1'b0;
      if (bus_if.busy !== (c >= 1 && c < exp_c)) ok_busy = 1'b0;
      if (hold_en && c < exp_c && (bus_if.hi !== hh || bus_if.lo !== hl)) ok_hold = 1'b0;
    end
    chk({name, "_stall"}, 32'(ok_stall), 32'd1);
    chk({name, "_ready"}, 32'(ok_ready), 32'd1);
    chk({name, "_busy"}, 32'(ok_busy), 32'd1);
    if (hold_en) chk({name, "_hold"}, 32'(ok_hold), 32'd1);
    chk({name, "_hi"}, bus_if.hi, eh);
    chk({name, "_lo"}, bus_if.lo, el);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok_nr;
    rst          = 1'b1;
    bus_if.start = 1'b0;
    bus_if.op    = 2'b00;
    bus_if.src_a = '0;
    bus_if.src_b = '0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(bus_if.busy), 32'd0);
    chk("reset_ready", 32'(bus_if.ready), 32'd0);
    chk("reset_hi", bus_if.hi, 32'd0);
    chk("reset_lo", bus_if.lo, 32'd0);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_result("multu_max", 0, 34, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 32'h0, 32'h0,
                -1, 1'b0, 2'b00, 32'h0, 32'h0);

    issue(2'b00, 32'hFFFF_FFFD, 32'd5);
    wait_result("mult_neg", 0, 34, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 32'h0, 32'h0,
                -1, 1'b1, 2'b11, 32'd100, 32'd7);
    wait_result("divu_b2b", 1, 34, 32'd2, 32'd14, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1,
                -1, 1'b0, 2'b00, 32'h0, 32'h0);

    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_result("div_neg", 0, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32'h0, 32'h0,
                -1, 1'b0, 2'b00, 32'h0, 32'h0);

    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result("div_ovf", 0, 34, 32'h0, 32'h8000_0000, 1'b0, 32'h0, 32'h0,
                -1, 1'b0, 2'b00, 32'h0, 32'h0);

    issue(2'b10, 32'h1234_5678, 32'h0);
    wait_result("div_zero", 0, 1, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0,
                -1, 1'b0, 2'b00, 32'h0, 32'h0);

    issue(2'b01, 32'h0, 32'd5);
    wait_result("multu_zero", 0, 34, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0,
                -1, 1'b0, 2'b00, 32'h0, 32'h0);

    issue(2'b11, 32'd100, 32'd7);
    wait_result("divu_ignore", 0, 34, 32'd2, 32'd14, 1'b1, 32'h0, 32'h0,
                5, 1'b0, 2'b00, 32'h0, 32'h0);

    issue(2'b11, 32'd100, 32'd7);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #2;
      if (c == 1) bus_if.start = 1'b0;
      if (c == 5) begin
        bus_if.start = 1'b1;
        bus_if.op    = 2'b00;
        bus_if.src_a = 32'd2;
        bus_if.src_b = 32'd3;
      end
      if (c == 6) bus_if.start = 1'b0;
      if (c == 10) rst = 1'b1;
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus_if.busy), 32'd0);
    chk("abort_ready", 32'(bus_if.ready), 32'd0);
    chk("abort_hi", bus_if.hi, 32'd0);
    chk("abort_lo", bus_if.lo, 32'd0);
    ok_nr = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus_if.ready !== 1'b0) ok_nr = 1'b0;
    end
    chk("abort_no_ready", 32'(ok_nr), 32'd1);

    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the decode stage.
- Executes mult, multu, div and divu on the forwarded rs/rt operands that decode places on the ID-to-EX bus.
- Produces 32-bit HI and LO results for the HI/LO register file.
- Holds the pipeline through a stall request while an operation is in flight.

Parameters:
- DATA_W, 32, operand and result width. Only 32 is supported; the iteration counter is sized for DATA_W steps.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request a new operation. Sampled only in IDLE or DONE.
- op  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
- src_a  input  32  rs operand (multiplicand or dividend).
- src_b  input  32  rt operand (multiplier or divisor).
- busy  output  1  registered; high in CALC and FIX.
- stallreq  output  1  combinational pipeline stall request.
- ready  output  1  registered; one-cycle pulse when a result becomes valid.
- hi  output  32  registered; product[63:32] or remainder.
- lo  output  32  registered; product[31:0] or quotient.

Behaviour:
- States: IDLE, CALC, FIX, DONE.
- Reset: state IDLE, counter 0, busy 0, ready 0, hi 0, lo 0. Reset mid-operation aborts the operation; the partial result is discarded and hi/lo read 0 on the next cycle.
- Cycle numbering: the cycle in which start=1 is accepted is cycle 0.
- Accept (IDLE or DONE with start=1):
  - Latch op.
  - Latch |src_a| and |src_b|. Magnitudes apply only for signed ops (00, 10); unsigned ops latch the raw values.
  - Latch the result sign. Product sign = a[31]^b[31]. Quotient sign = a[31]^b[31]. Remainder sign = a[31].
  - Next state is CALC with counter 0.
- Divide by zero (op 1x and src_b==0 at accept):
  - Next state is DONE directly.
  - hi = src_a, lo = 32'hFFFF_FFFF, ready=1 in cycle 1.
  - No sign fix is applied.
- CALC: performs one iteration per cycle for 32 cycles (cycles 1..32), with the counter incrementing 0..31.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring, one quotient bit per cycle, MSB first; 32-bit partial remainder plus 1 guard bit.
  - On counter==31, next state is FIX.
- FIX (cycle 33): negate the magnitude results if the latched signs require it.
  - Product: negate the 64-bit result.
  - Divide: quotient and remainder negate independently.
  - Register hi/lo at the end of the cycle.
  - Next state is DONE.
- DONE (cycle 34): ready=1 for exactly this cycle.
  - hi/lo are valid from cycle 34 and hold until the next accept completes or reset.
  - Without start, next state is IDLE.
  - With start, accept the new operation (back-to-back allowed).
- hi/lo are not altered during CALC/FIX of a new operation until FIX (or the divide-by-zero accept) writes them.
- busy = 1 in CALC and FIX; otherwise 0.
- stallreq = (start & (state==IDLE | state==DONE)) | busy.
  - High in cycles 0..33.
  - Low in cycle 34, so the instruction leaves EX together with the ready pulse.
  - For divide by zero, stallreq is high in cycle 0 only.
- start while busy is ignored: no re-latch and no effect on the current operation. op/src values outside accept are don't-care.
- Signed overflow div 0x80000000 / 0xFFFFFFFF: magnitudes are 0x80000000/1; both operands negative, so no quotient negate. Result lo=0x80000000, hi=0.
- Zero operands follow the normal 32-iteration path, with no early exit.

Test Plan:
- multu src_a=0xFFFFFFFF src_b=0xFFFFFFFF -> stallreq high cycles 0..33; ready high only in cycle 34 with hi=0xFFFFFFFE, lo=0x00000001.
- mult src_a=0xFFFFFFFD (-3) src_b=5 -> cycle 34: hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then divu 100/7 started in cycle 34 -> cycle 68: lo=0x0000000E, hi=0x00000002, with hi/lo holding the mult result through cycle 67.
- div src_a=0xFFFFFFF9 (-7) src_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- div src_a=0x12345678 src_b=0 -> ready in cycle 1, hi=0x12345678, lo=0xFFFFFFFF, busy never asserted.
- divu 100/7 with a second start (mult 2*3) pulsed in cycle 5 -> ignored; cycle 34 result is divu's. Repeat with rst in cycle 10 -> cycle 11: busy=0, ready=0, hi=lo=0, no ready pulse thereafter.
